buffer_memory: RTL and testbench
================================

// Module: buffer_memory
// PURPOSE
//  Fixed-depth circular delay buffer. Samples data_in on every clock edge
//  and replays it on data_out exactly DEPTH cycles later. Sits between a
//  producer and a consumer stage that need a fixed, flushable pipeline delay.
//  flush discards all buffered samples without asserting reset.
// PARAMETERS
//  DATA_WIDTH  64  width of data_in, data_out and each storage word
//  DEPTH       4   number of storage words = delay in cycles; power of 2, >= 2
//  AW          $clog2(DEPTH)  local parameter: pointer width
// PORTS
//  clk       in   1           single clock; all state updates on rising edge
//  rst       in   1           asynchronous, active-low reset
//  flush     in   1           synchronous clear of buffer contents, active-high
//  data_in   in   DATA_WIDTH  sample written every cycle
//  data_out  out  DATA_WIDTH  registered output: sample written DEPTH cycles ago
// BEHAVIOUR
//  State: mem[0..DEPTH-1] of DATA_WIDTH, wr_ptr (AW bits), count (AW+1 bits,
//   saturates at DEPTH), data_out register.
//  Reset (rst=0, any time, async): wr_ptr=0, count=0, data_out=0. mem is not
//   cleared; count guarantees stale words are never output.
//  Priority per rising edge: reset > flush > normal.
//  Flush (flush=1 at edge): wr_ptr=0, count=0, data_out=0. data_in that cycle
//   is discarded. Holding flush keeps data_out at 0 indefinitely.
//  Normal edge, in this order, using pre-edge values:
//   - if count==DEPTH: data_out <= mem[wr_ptr] (oldest word, read before
//     overwrite); else data_out <= 0.
//   - mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1 (wraps DEPTH-1 -> 0).
//   - count <= min(count+1, DEPTH).
//  Latency: data_in sampled at edge k appears on data_out after edge k+DEPTH
//   and holds for one cycle. After reset or flush, data_out is 0 for the first
//   DEPTH edges, then real data follows.
//  Throughput: one sample in and one out per cycle; no stalls, no handshake.
//  Wrap-around: read and write share the same address on every primed cycle;
//   read must return the old word (read-before-write).
//  Reset or flush mid-stream: all in-flight samples are lost; refill restarts
//   from empty.
//  No arithmetic on data; values pass through bit-exact.
// TESTING
//  1. rst=0 for 2 edges, data_in=7 -> data_out=0 throughout. Release rst ->
//     data_out stays 0 for 4 edges.
//  2. After reset, data_in=20 for 1 cycle, then 22 held -> data_out 0,0,0,0,
//     then 20 on the 5th edge, then 22 from the 6th edge onward.
//  3. Stream 1,2,3,...,12 on consecutive edges -> data_out equals the input
//     from 4 edges earlier, across at least two pointer wraps.
//  4. Primed buffer, flush=1 for 2 edges while data_in=50 -> data_out=0 on the
//     first flushed edge. After release with data_in=50 held, data_out=0 for 4
//     edges, then 50.
//  5. Pulse rst low between clock edges mid-stream -> data_out goes to 0
//     immediately (async). After release, it refills with a 4-cycle latency.
//  6. flush and rst asserted together -> reset behaviour. flush=1 with data_in
//     changing -> data_out stays 0.

Source files
------------

// File: rtl/buffer_memory.sv
// buffer_memory: fixed-depth circular delay buffer. Every sample written on
// data_in is replayed on data_out exactly DEPTH clock edges later. A fill
// counter keeps stale storage from ever reaching the output after reset or
// flush, so the storage array itself never needs clearing.
module buffer_memory #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW:0]           count;
  logic                  primed;

  // Buffer holds DEPTH valid words: the slot about to be overwritten is the oldest.
  assign primed = (count == FULL);

  // Storage write; the read of the same slot in the control block sees the old word.
  always_ff @(posedge clk) begin
    if (rst && !flush) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointer, fill counter and output register; reset beats flush beats normal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      data_out <= primed ? mem[wr_ptr] : '0;
      wr_ptr   <= wr_ptr + 1'b1;
      if (!primed) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_buffer_memory.sv
// Directed bench for buffer_memory (DATA_WIDTH=64, DEPTH=4).
module tb_buffer_memory;

  localparam int DW = 64;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;

  int checks;
  int failures;

  buffer_memory #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    flush    = 1'b0;
    data_in  = 64'd7;
    rst      = 1'b0;

    // Test 1: held in reset, then release with 7 held.
    step();
    check_eq("t1_rst_e1", data_out, 64'd0);
    step();
    check_eq("t1_rst_e2", data_out, 64'd0);
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq($sformatf("t1_fill_e%0d", k), data_out, 64'd0);
    end
    step();
    check_eq("t1_first_data", data_out, 64'd7);

    // Test 2: 20 for one cycle, then 22 held.
    do_reset();
    data_in = 64'd20;
    step();
    check_eq("t2_e1", data_out, 64'd0);
    data_in = 64'd22;
    for (int k = 2; k <= 4; k++) begin
      step();
      check_eq($sformatf("t2_e%0d", k), data_out, 64'd0);
    end
    step();
    check_eq("t2_e5", data_out, 64'd20);
    for (int k = 6; k <= 8; k++) begin
      step();
      check_eq($sformatf("t2_e%0d", k), data_out, 64'd22);
    end

    // Test 3: stream 1..12 then zeros; output lags input by 4 edges, wrapping the pointer.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      data_in = (k <= 12) ? DW'(k) : 64'd0;
      step();
      check_eq($sformatf("t3_e%0d", k), data_out, (k > 4) ? DW'(k - 4) : 64'd0);
    end

    // Wide pattern to confirm bit-exact pass-through of the full word.
    data_in = 64'hDEAD_BEEF_1234_5678;
    step();
    data_in = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    step();
    step();
    step();
    check_eq("t3_wide_a", data_out, 64'hDEAD_BEEF_1234_5678);
    step();
    check_eq("t3_wide_b", data_out, 64'hFFFF_FFFF_FFFF_FFFF);

    // Test 4: primed buffer, flush for 2 edges with 50, then refill with 50.
    flush   = 1'b1;
    data_in = 64'd50;
    step();
    check_eq("t4_flush_e1", data_out, 64'd0);
    step();
    check_eq("t4_flush_e2", data_out, 64'd0);
    flush = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq($sformatf("t4_refill_e%0d", k), data_out, 64'd0);
    end
    step();
    check_eq("t4_refill_e5", data_out, 64'd50);

    // Test 5: asynchronous reset pulse between edges mid-stream.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      data_in = DW'(100 + k);
      step();
    end
    check_eq("t5_primed", data_out, 64'd102);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t5_async_clear", data_out, 64'd0);
    #1;
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      data_in = DW'(200 + k);
      step();
      check_eq($sformatf("t5_refill_e%0d", k), data_out, (k == 5) ? 64'd201 : 64'd0);
    end

    // Test 6: reset and flush together, then flush alone with changing input.
    rst     = 1'b0;
    flush   = 1'b1;
    data_in = 64'd9;
    #1;
    check_eq("t6_both_async", data_out, 64'd0);
    step();
    check_eq("t6_both_edge", data_out, 64'd0);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      data_in = DW'(30 + k);
      step();
      check_eq($sformatf("t6_flush_e%0d", k), data_out, 64'd0);
    end
    flush   = 1'b0;
    data_in = 64'd77;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_eq($sformatf("t6_refill_e%0d", k), data_out, (k == 5) ? 64'd77 : 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
